mouse_packet_assembler: RTL

//  Downstream of MouseReceiver. Consumes its byte stream and assembles standard 3-byte PS/2 mouse packets.

---
 rtl/mouse_pkg.sv | 34 +++
 rtl/mouse_axis_accum.sv | 57 +++++
 rtl/mouse_packet_assembler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet path.
//  - FSM state encoding for the 3-byte packet assembler
//  - bit positions inside the PS/2 status byte
//  - MouseReceiver error-code values
//  - helper to build the 9-bit signed delta from sign bit and data byte
package mouse_pkg;

  typedef enum logic [1:0] {
    S_STATUS = 2'd0,
    S_DX     = 2'd1,
    S_DY     = 2'd2
  } pkt_state_e;

  // Status byte bit indices
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XSIGN = 4;
  localparam int YSIGN = 5;
  localparam int XOVF  = 6;
  localparam int YOVF  = 7;

  // BYTE_ERROR_CODE values
  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_PARITY = 2'b01;
  localparam logic [1:0] ERR_STOP   = 2'b10;

  // The PS/2 delta is a 9-bit two's complement value whose MSB lives in the status byte.
  function automatic logic signed [8:0] make_delta(input logic sign_bit, input logic [7:0] mag);
    return $signed({sign_bit, mag});
  endfunction

endpackage

// File: rtl/mouse_axis_accum.sv
// One axis of the absolute cursor position.
//  clk      in   clock
//  rst_n    in   asynchronous active-low reset (position returns to MAX/2)
//  commit_i in   apply delta_i this cycle
//  delta_i  in   9-bit signed movement
//  ovf_i    in   overflow flag for this axis; movement ignored when set
//  pos_o    out  clamped position, 0..MAX
module mouse_axis_accum #(
  parameter int POS_W  = 8,
  parameter int MAX    = 159,
  parameter int INVERT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                commit_i,
  input  logic signed [8:0]   delta_i,
  input  logic                ovf_i,
  output logic [POS_W-1:0]    pos_o
);

  // Two extra bits hold any pos +/- delta without wrap; never narrower than the delta itself.
  localparam int EXT_W = (POS_W + 2 > 10) ? POS_W + 2 : 10;
  localparam logic [POS_W-1:0]        CENTRE  = POS_W'(MAX / 2);
  localparam logic signed [EXT_W-1:0] MAX_EXT = EXT_W'(MAX);

  logic [POS_W-1:0]        pos_q, pos_d;
  logic signed [EXT_W-1:0] pos_ext, delta_ext, sum;

  function automatic logic [POS_W-1:0] clamp_pos(input logic signed [EXT_W-1:0] s);
    if (s < 0)
      return '0;
    else if (s > MAX_EXT)
      return POS_W'(MAX);
    else
      return s[POS_W-1:0];
  endfunction

  always_comb begin
    pos_ext   = $signed({{(EXT_W-POS_W){1'b0}}, pos_q});
    delta_ext = ovf_i ? '0 : $signed({{(EXT_W-9){delta_i[8]}}, delta_i});
    if (INVERT != 0)
      sum = pos_ext - delta_ext;
    else
      sum = pos_ext + delta_ext;
    pos_d = commit_i ? clamp_pos(sum) : pos_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pos_q <= CENTRE;
    else
      pos_q <= pos_d;
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/mouse_packet_assembler.sv
// Assembles 3-byte PS/2 mouse packets (status, dX, dY) from the MouseReceiver byte stream
// and keeps clamped absolute cursor coordinates.
//  CLK             in   system clock
//  RESET           in   asynchronous active-low reset
//  BYTE_READ       in   received byte
//  BYTE_ERROR_CODE in   [0] parity error, [1] stop-bit error
//  BYTE_READY      in   one-cycle strobe qualifying BYTE_READ/BYTE_ERROR_CODE
//  READ_ENABLE     out  receiver enable, high from the first edge after reset
//  MOUSE_STATUS    out  last committed status byte
//  MOUSE_DX/DY     out  last committed 9-bit signed deltas (raw, even on overflow)
//  MOUSE_X/Y       out  clamped absolute position
//  PACKET_VALID    out  one-cycle pulse when a packet commits
//  PACKET_ERROR    out  one-cycle pulse when a packet is discarded
module mouse_packet_assembler
  import mouse_pkg::*;
#(
  parameter int POS_W          = 8,
  parameter int MAX_X          = 159,
  parameter int MAX_Y          = 119,
  parameter int Y_INVERT       = 1,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [7:0]          BYTE_READ,
  input  logic [1:0]          BYTE_ERROR_CODE,
  input  logic                BYTE_READY,
  output logic                READ_ENABLE,
  output logic [7:0]          MOUSE_STATUS,
  output logic signed [8:0]   MOUSE_DX,
  output logic signed [8:0]   MOUSE_DY,
  output logic [POS_W-1:0]    MOUSE_X,
  output logic [POS_W-1:0]    MOUSE_Y,
  output logic                PACKET_VALID,
  output logic                PACKET_ERROR
);

  localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  pkt_state_e         state_q;
  logic               read_en_q;
  logic [7:0]         hold_status_q, hold_dx_q;
  logic [7:0]         status_q;
  logic signed [8:0]  dx_q, dy_q;
  logic               valid_q, error_q;
  logic [CNT_W-1:0]   tmo_q;

  logic               byte_acc;
  logic               byte_bad;
  logic               commit_d;
  logic signed [8:0]  x_delta, y_delta;

  // Strobes arriving before the receiver is enabled are not ours to consume.
  assign byte_acc = BYTE_READY && read_en_q;
  assign byte_bad = (BYTE_ERROR_CODE != ERR_NONE);
  // Position registers update on the same edge that raises PACKET_VALID.
  assign commit_d = byte_acc && !byte_bad && (state_q == S_DY);

  // dY comes straight from the bus: it is the byte being committed right now.
  assign x_delta = make_delta(hold_status_q[XSIGN], hold_dx_q);
  assign y_delta = make_delta(hold_status_q[YSIGN], BYTE_READ);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= S_STATUS;
      read_en_q     <= 1'b0;
      hold_status_q <= '0;
      hold_dx_q     <= '0;
      status_q      <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      valid_q       <= 1'b0;
      error_q       <= 1'b0;
      tmo_q         <= '0;
    end else begin
      read_en_q <= 1'b1;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      if (byte_acc) begin
        tmo_q <= '0;
        if (byte_bad) begin
          state_q <= S_STATUS;
          error_q <= 1'b1;
        end else begin
          case (state_q)
            S_STATUS: begin
              if (!BYTE_READ[SYNC]) begin
                // Bit 3 is always set in a status byte; anything else means we are misaligned.
                error_q <= 1'b1;
              end else begin
                hold_status_q <= BYTE_READ;
                state_q       <= S_DX;
              end
            end
            S_DX: begin
              hold_dx_q <= BYTE_READ;
              state_q   <= S_DY;
            end
            S_DY: begin
              status_q <= hold_status_q;
              dx_q     <= x_delta;
              dy_q     <= y_delta;
              valid_q  <= 1'b1;
              state_q  <= S_STATUS;
            end
            default: state_q <= S_STATUS;
          endcase
        end
      end else if (BYTE_READY || state_q == S_STATUS) begin
        tmo_q <= '0;
      end else if (tmo_q == TMO_LIMIT) begin
        // Inter-byte gap too long: abandon the partial packet.
        state_q <= S_STATUS;
        error_q <= 1'b1;
        tmo_q   <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  mouse_axis_accum #(.POS_W(POS_W), .MAX(MAX_X), .INVERT(0)) u_axis_x (
    .clk      (CLK),
    .rst_n    (RESET),
    .commit_i (commit_d),
    .delta_i  (x_delta),
    .ovf_i    (hold_status_q[XOVF]),
    .pos_o    (MOUSE_X)
  );

  mouse_axis_accum #(.POS_W(POS_W), .MAX(MAX_Y), .INVERT(Y_INVERT)) u_axis_y (
    .clk      (CLK),
    .rst_n    (RESET),
    .commit_i (commit_d),
    .delta_i  (y_delta),
    .ovf_i    (hold_status_q[YOVF]),
    .pos_o    (MOUSE_Y)
  );

  assign READ_ENABLE  = read_en_q;
  assign MOUSE_STATUS = status_q;
  assign MOUSE_DX     = dx_q;
  assign MOUSE_DY     = dy_q;
  assign PACKET_VALID = valid_q;
  assign PACKET_ERROR = error_q;

endmodule
